// File: rtl/cnt_pkg.sv
// ---------------------------------------------------------------------------
// cnt_pkg
// Shared constants and helpers for the loadable counter.
//   CNT_WIDTH_DEFAULT : default bit width of the count register
//   is_all_ones()     : decode used to flag the terminal count
// ---------------------------------------------------------------------------
package cnt_pkg;

    localparam int CNT_WIDTH_DEFAULT = 4;

    // True when the low 'width' bits of 'value' are all ones. Bits above
    // 'width' are ignored, so callers can pass a zero-extended register.
    function automatic logic is_all_ones(input logic [31:0] value,
                                         input int          width);
        logic [31:0] mask;
        if (width >= 32) begin
            mask = '1;
        end else begin
            mask = (32'd1 << width) - 32'd1;
        end
        return (value & mask) == mask;
    endfunction

endpackage

// File: rtl/cnt_next_mux.sv
// ---------------------------------------------------------------------------
// cnt_next_mux
// Combinational next-state select for the loadable counter.
// Priority: reset, then parallel load, then increment (wraps modulo 2**WIDTH).
// Ports:
//   rst_i   : synchronous reset request, forces next count to zero
//   load_i  : parallel load request
//   data_i  : parallel load value
//   count_i : current registered count
//   next_o  : value the count register takes at the next rising edge
// ---------------------------------------------------------------------------
module cnt_next_mux
    import cnt_pkg::*;
#(
    parameter int WIDTH = CNT_WIDTH_DEFAULT
) (
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic [WIDTH-1:0] count_i,
    output logic [WIDTH-1:0] next_o
);

    always_comb begin
        next_o = count_i + WIDTH'(1);   // natural overflow gives the wrap to 0
        if (rst_i) begin
            next_o = '0;
        end else if (load_i) begin
            next_o = data_i;
        end
    end

endmodule

// File: rtl/loadable_counter.sv
// ---------------------------------------------------------------------------
// loadable_counter
// Free-running binary up-counter with a synchronous parallel load.
// Every rising edge either resets, loads DataIn, or increments the count.
// Ports:
//   Clk     : system clock, all state changes on its rising edge
//   Rst     : synchronous active-high reset (wins over Load and counting)
//   DataIn  : parallel load value
//   Load    : 1 = load DataIn on the next rising edge, 0 = count
//   DataOut : current count, straight from the register
//   TermCnt : high while DataOut is all ones, for cascading counters
// ---------------------------------------------------------------------------
module loadable_counter
    import cnt_pkg::*;
#(
    parameter int WIDTH = CNT_WIDTH_DEFAULT
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic [WIDTH-1:0] DataIn,
    input  logic             Load,
    output logic [WIDTH-1:0] DataOut,
    output logic             TermCnt
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // Reset is folded into the next-state select, so the register itself
    // is a plain D flop and nothing reaches DataOut without passing it.
    cnt_next_mux #(
        .WIDTH (WIDTH)
    ) u_next_mux (
        .rst_i   (Rst),
        .load_i  (Load),
        .data_i  (DataIn),
        .count_i (count_q),
        .next_o  (count_d)
    );

    always_ff @(posedge Clk) begin
        count_q <= count_d;
    end

    assign DataOut = count_q;
    assign TermCnt = is_all_ones(32'(count_q), WIDTH);

endmodule

// File: tb/tb_loadable_counter.sv
// ---------------------------------------------------------------------------
// tb_loadable_counter
// Self-checking bench for loadable_counter. The driver applies one operation
// per clock and pushes the expected {TermCnt, DataOut} into exp_q; a monitor
// samples the DUT just after each rising edge and compares against the queue.
// ---------------------------------------------------------------------------
module tb_loadable_counter;

    localparam int W   = 4;
    localparam int MOD = 1 << W;

    logic         Clk;
    logic         Rst;
    logic [W-1:0] DataIn;
    logic         Load;
    logic [W-1:0] DataOut;
    logic         TermCnt;

    logic [W:0]   exp_q[$];
    int           model_cnt;
    int           n_checks;
    int           n_fails;

    loadable_counter #(
        .WIDTH (W)
    ) dut (
        .Clk     (Clk),
        .Rst     (Rst),
        .DataIn  (DataIn),
        .Load    (Load),
        .DataOut (DataOut),
        .TermCnt (TermCnt)
    );

    // ---------------- clock / reset block ----------------
    initial begin
        Clk    = 1'b0;
        Rst    = 1'b0;
        Load   = 1'b0;
        DataIn = '0;
    end
    always #5 Clk = ~Clk;

    // ---------------- reference model + driver ----------------
    // Model: an integer counter following the rules reset > load > +1 mod 2**W.
    function automatic logic [W:0] expect_word(input int cnt);
        logic [W:0] e;
        e = {(cnt == MOD - 1), W'(cnt)};
        return e;
    endfunction

    task automatic drive(input logic rst, input logic load, input logic [W-1:0] din);
        @(negedge Clk);
        Rst    = rst;
        Load   = load;
        DataIn = din;
        if (rst)       model_cnt = 0;
        else if (load) model_cnt = int'(din);
        else           model_cnt = (model_cnt + 1) % MOD;
        exp_q.push_back(expect_word(model_cnt));
    endtask

    // Wiggle Load/DataIn between edges and confirm the output does not move.
    task automatic glitch_check();
        logic [W-1:0] want;
        @(posedge Clk);
        #3;
        Load   = ~Load;
        DataIn = ~DataIn;
        #1;
        want = W'(model_cnt);
        n_checks++;
        if (DataOut !== want) begin
            n_fails++;
            $display("FAIL mid_cycle_hold: DataOut got %0d need %0d", DataOut, want);
        end
    endtask

    // ---------------- scoreboard monitor ----------------
    initial begin
        logic [W:0] e;
        logic [W:0] got;
        forever begin
            @(posedge Clk);
            #1;
            if (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                got = {TermCnt, DataOut};
                n_checks++;
                if (got !== e) begin
                    n_fails++;
                    $display("FAIL count_term @%0t: got DataOut=%0d TermCnt=%0b need DataOut=%0d TermCnt=%0b",
                             $time, got[W-1:0], got[W], e[W-1:0], e[W]);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int wait_cycles;
        n_checks  = 0;
        n_fails   = 0;
        model_cnt = 0;

        // Reset then count three edges: 0,1,2,3
        drive(1'b1, 1'b0, 4'd0);
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 4'd0);

        // Load 7 then count through the wrap: 7,8..15,0,1
        drive(1'b0, 1'b1, 4'd7);
        for (int i = 0; i < 10; i++) drive(1'b0, 1'b0, 4'd0);

        // Load 14 -> 15 (TermCnt) -> 0
        drive(1'b0, 1'b1, 4'd14);
        drive(1'b0, 1'b0, 4'd0);
        drive(1'b0, 1'b0, 4'd0);

        // At 15, load 15: stays 15; release wraps to 0
        drive(1'b0, 1'b1, 4'd15);
        drive(1'b0, 1'b1, 4'd15);
        drive(1'b0, 1'b0, 4'd0);

        // Consecutive loads follow DataIn, no counting
        drive(1'b0, 1'b1, 4'd3);
        drive(1'b0, 1'b1, 4'd12);
        drive(1'b0, 1'b1, 4'd5);

        // Reset and load together: reset wins, then counts to 1
        drive(1'b1, 1'b1, 4'd9);
        drive(1'b0, 1'b0, 4'd0);

        // Mid-count reset at 11, then toggling inputs between edges
        drive(1'b0, 1'b1, 4'd10);
        drive(1'b0, 1'b0, 4'd0);
        drive(1'b1, 1'b0, 4'd0);
        glitch_check();
        drive(1'b0, 1'b0, 4'd6);
        glitch_check();
        drive(1'b0, 1'b1, 4'd13);
        glitch_check();

        // Randomized traffic
        for (int i = 0; i < 300; i++) begin
            drive(($urandom_range(0, 19) == 0),
                  ($urandom_range(0, 3) == 0),
                  W'($urandom_range(0, MOD - 1)));
            if ($urandom_range(0, 15) == 0) glitch_check();
        end

        // Drain the scoreboard with a bounded wait
        wait_cycles = 0;
        while (exp_q.size() > 0 && wait_cycles < 10) begin
            @(posedge Clk);
            wait_cycles++;
        end
        @(negedge Clk);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fails++;
            $display("FAIL drain: %0d expected outputs left, need 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fails);
        $finish;
    end

endmodule
